// File: rtl/capture_ctrl.sv
// capture_ctrl: arms a trigger, writes strobed samples into a circular sample
// memory, runs a post-trigger delay, then reads the capture back newest-first.
// Ports: clk_i/rst_i (sync, active-high), cmd_i {DLY,RD} loaded by set_cnt_i,
//   arm_i, stb_i, run_i, tx_rdy_i in; trg_arm_o, we_o, addr_o, rd_vld_o,
//   busy_o, done_o out.
// Option: define CAPTURE_CTRL_ABORT_EN to add abort_i (return to IDLE at once).
module capture_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cmd_i,
    input  logic              set_cnt_i,
    input  logic              arm_i,
    input  logic              stb_i,
    input  logic              run_i,
    input  logic              tx_rdy_i,
`ifdef CAPTURE_CTRL_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              trg_arm_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rd_vld_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW = ADDR_W + 1;
    localparam logic [18:0] DEPTH19 = 19'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DELAY,
        READOUT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       rd_q, rd_d;
    logic [15:0]       dly_q, dly_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [18:0]       dly_cnt_q, dly_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              vld_q, vld_d;
    logic              trg_arm_q, trg_arm_d;

    logic              abort;
    logic              act;
    logic              hs;
    logic [18:0]       nd;
    logic [18:0]       nr19;
    logic [CW-1:0]     nr;

`ifdef CAPTURE_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Sync reset still has the old state visible; outputs are masked meanwhile.
    assign act  = ~rst_i;
    assign hs   = (state_q == READOUT) && vld_q && tx_rdy_i;
    assign nd   = {1'b0, dly_q, 2'b00} + 19'd4;
    assign nr19 = {1'b0, rd_q, 2'b00} + 19'd4;
    assign nr   = (nr19 > DEPTH19) ? DEPTH19[CW-1:0] : nr19[CW-1:0];

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        dly_d     = dly_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dly_cnt_d = dly_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        vld_d     = 1'b0;
        trg_arm_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (set_cnt_i) begin
                    rd_d  = cmd_i[15:0];
                    dly_d = cmd_i[31:16];
                end
                if (arm_i) begin
                    state_d   = ARMED;
                    trg_arm_d = 1'b1;
                end
            end
            ARMED: begin
                if (stb_i) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (run_i) begin
                    state_d = DELAY;
                    // A strobe on the trigger cycle is the first delay sample.
                    dly_cnt_d = stb_i ? nd - 19'd1 : nd;
                end
            end
            DELAY: begin
                if (stb_i) begin
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    dly_cnt_d = dly_cnt_q - 19'd1;
                    if (dly_cnt_q == 19'd1) begin
                        state_d  = READOUT;
                        rd_ptr_d = wr_ptr_q;
                        rd_cnt_d = nr;
                    end
                end
            end
            READOUT: begin
                // vld_q low for one cycle covers the RAM read latency.
                vld_d = ~hs;
                if (hs) begin
                    rd_ptr_d = rd_ptr_q - 1'b1;
                    rd_cnt_d = rd_cnt_q - CW'(1);
                    if (rd_cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = IDLE;
            wr_ptr_d  = wr_ptr_q;
            vld_d     = 1'b0;
            trg_arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            dly_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dly_cnt_q <= '0;
            rd_cnt_q  <= '0;
            vld_q     <= 1'b0;
            trg_arm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            dly_q     <= dly_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dly_cnt_q <= dly_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            vld_q     <= vld_d;
            trg_arm_q <= trg_arm_d;
        end
    end

    always_comb begin
        trg_arm_o = act && trg_arm_q;
        busy_o    = act && (state_q != IDLE);
        rd_vld_o  = act && (state_q == READOUT) && vld_q;
        done_o    = act && !abort && hs && (rd_cnt_q == CW'(1));
        we_o      = act && !abort && stb_i
                    && ((state_q == ARMED) || (state_q == DELAY));
        addr_o    = '0;
        if (act) begin
            unique case (state_q)
                ARMED, DELAY: addr_o = wr_ptr_q;
                READOUT:      addr_o = rd_ptr_q;
                default:      addr_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized capture scenarios on a 1024-deep and an 8-deep
// instance, each checked cycle by cycle against a transaction-level model.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        set_cnt, arm, stb, run, tx_rdy, abort;
    logic        sel;

    logic       a_trg, a_we, a_vld, a_busy, a_done;
    logic [9:0] a_addr;
    logic       b_trg, b_we, b_vld, b_busy, b_done;
    logic [2:0] b_addr;

    int vectors = 0;
    int errors  = 0;

    // Model state that persists across captures.
    int wcount;
    int mrd, mdly;

    always #5 clk = ~clk;

    capture_ctrl #(.ADDR_W(10)) dut_a (
        .clk_i(clk), .rst_i(rst | sel), .cmd_i(cmd),
        .set_cnt_i(set_cnt), .arm_i(arm), .stb_i(stb),
        .run_i(run), .tx_rdy_i(tx_rdy),
`ifdef CAPTURE_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .trg_arm_o(a_trg), .we_o(a_we), .addr_o(a_addr),
        .rd_vld_o(a_vld), .busy_o(a_busy), .done_o(a_done)
    );

    capture_ctrl #(.ADDR_W(3)) dut_b (
        .clk_i(clk), .rst_i(rst | ~sel), .cmd_i(cmd),
        .set_cnt_i(set_cnt), .arm_i(arm), .stb_i(stb),
        .run_i(run), .tx_rdy_i(tx_rdy),
`ifdef CAPTURE_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .trg_arm_o(b_trg), .we_o(b_we), .addr_o(b_addr),
        .rd_vld_o(b_vld), .busy_o(b_busy), .done_o(b_done)
    );

    logic [14:0] got;
    assign got = sel ? {b_trg, b_we, b_vld, b_busy, b_done, 7'b0, b_addr}
                     : {a_trg, a_we, a_vld, a_busy, a_done, a_addr};

    task automatic idle_inputs();
        rst = 1'b0; set_cnt = 1'b0; arm = 1'b0; stb = 1'b0;
        run = 1'b0; tx_rdy = 1'b0; abort = 1'b0; cmd = $urandom;
    endtask

    task automatic test_reset(input bit s);
        sel = s;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            rst = 1'b1;
            arm = 1'($urandom); stb = 1'($urandom);
            set_cnt = 1'($urandom); tx_rdy = 1'($urandom);
            #3;
            vectors++;
            if (got !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold got=%h exp=%h", got, 15'd0);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        stb = 1'b1;
        #3;
        vectors++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=%h", got, 15'd0);
        end
        @(posedge clk); #1;
        wcount = 0; mrd = 0; mdly = 0;
    endtask

    // ph: 0 load-only, 1 arm, 2 pre-trigger, 3 trigger, 4 delay, 5 readout,
    // 6 finished, 7 aborted.
    task automatic test_capture(input string nm, input bit load,
                                input logic [31:0] c, input bit sep,
                                input int pre, input int stb_pct,
                                input int rdy_pct, input int stall,
                                input int rst_at, input int abort_at);
        int depth = sel ? 8 : 1024;
        int ph, nd, dcnt, left, raddr, last, hsn, cyc, stall_left, wrote;
        bit vld_e, trg_e, ry, do_rst, do_abort;
        logic [14:0] exp;
        logic e_we, e_vld, e_busy, e_done;
        logic [9:0] e_addr;
        ph = (load && sep) ? 0 : 1;
        trg_e = 0; vld_e = 0; stall_left = stall; wrote = 0;
        nd = 0; dcnt = 0; left = 0; raddr = 0; last = 0; hsn = 0; cyc = 0;
        while (ph < 6 && cyc < 20000) begin
            cyc++;
            idle_inputs();
            do_rst = 0; do_abort = 0; ry = 0;
            e_we = 0; e_vld = 0; e_done = 0; e_addr = '0;
            e_busy = (ph >= 2);
            case (ph)
                0: begin
                    set_cnt = 1'b1; cmd = c;
                    run = 1'($urandom); stb = 1'($urandom);
                end
                1: begin
                    arm = 1'b1;
                    if (load && !sep) begin set_cnt = 1'b1; cmd = c; end
                    run = 1'($urandom); stb = 1'($urandom);
                end
                2: begin
                    stb = ($urandom_range(99) < stb_pct);
                    set_cnt = 1'($urandom); arm = 1'($urandom);
                    e_we = stb; e_addr = 10'(wcount % depth);
                end
                3: begin
                    run = 1'b1;
                    stb = (stb_pct == 100) ? 1'b0 : 1'($urandom);
                    e_we = stb; e_addr = 10'(wcount % depth);
                end
                4: begin
                    stb = ($urandom_range(99) < stb_pct);
                    set_cnt = 1'($urandom); arm = 1'($urandom);
                    if (abort_at >= 0 && dcnt == abort_at) begin
                        do_abort = 1; abort = 1'b1; stb = 1'b0;
                    end
                    e_we = stb; e_addr = 10'(wcount % depth);
                end
                default: begin
                    ry = ($urandom_range(99) < rdy_pct);
                    if (vld_e && stall_left > 0) begin
                        ry = 0; stall_left--;
                    end
                    tx_rdy = ry;
                    stb = 1'($urandom); run = 1'($urandom);
                    arm = 1'($urandom);
                    e_vld = vld_e; e_addr = 10'(raddr);
                    e_done = vld_e && ry && (left == 1);
                    if (rst_at >= 0 && hsn == rst_at) begin
                        do_rst = 1; rst = 1'b1;
                    end
                end
            endcase
            exp = {trg_e, e_we, e_vld, e_busy, e_done, e_addr};
            if (do_rst) exp = '0;
            #3;
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s ph%0d cyc%0d got=%h exp=%h",
                         nm, ph, cyc, got, exp);
            end
            trg_e = (ph == 1);
            case (ph)
                0: begin mrd = c[15:0]; mdly = c[31:16]; ph = 1; end
                1: begin
                    if (load && !sep) begin
                        mrd = c[15:0]; mdly = c[31:16];
                    end
                    ph = (pre == 0) ? 3 : 2;
                end
                2: begin
                    if (stb) begin wcount++; wrote++; end
                    if (wrote == pre) ph = 3;
                end
                3: begin
                    nd = 4 * (mdly + 1);
                    dcnt = stb ? 1 : 0;
                    if (stb) begin last = wcount % depth; wcount++; end
                    ph = 4;
                end
                4: begin
                    if (do_abort) ph = 7;
                    else if (stb) begin
                        last = wcount % depth; wcount++; dcnt++;
                        if (dcnt == nd) begin
                            ph = 5; raddr = last; vld_e = 0; hsn = 0;
                            left = 4 * (mrd + 1);
                            if (left > depth) left = depth;
                        end
                    end
                end
                default: begin
                    if (do_rst) begin
                        wcount = 0; mrd = 0; mdly = 0; ph = 6;
                    end else if (vld_e && ry) begin
                        left--; hsn++; vld_e = 0;
                        raddr = (raddr + depth - 1) % depth;
                        if (left == 0) ph = 6;
                    end else begin
                        vld_e = 1;
                    end
                end
            endcase
            @(posedge clk); #1;
        end
        vectors++;
        if (ph < 6) begin
            errors++;
            $display("FAIL %s timeout got=%h exp=done", nm, got);
        end
        idle_inputs();
        stb = 1'b1;
        #3;
        vectors++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL %s end_idle got=%h exp=%h", nm, got, 15'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input bit s, input int n);
        logic [31:0] c;
        int rd;
        test_reset(s);
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(5) == 0) ? $urandom_range(400)
                                          : $urandom_range(3);
            c = {16'($urandom_range(5)), 16'(rd)};
            test_capture("random", 1'($urandom), c, 1'($urandom),
                         $urandom_range(12), $urandom_range(30, 100),
                         (rd > 3) ? $urandom_range(60, 100)
                                  : $urandom_range(20, 100),
                         $urandom_range(5),
                         ($urandom_range(3) == 0) ? $urandom_range(6) : -1,
                         -1);
        end
    endtask

    initial begin
        sel = 1'b0;
        idle_inputs();
        wcount = 0; mrd = 0; mdly = 0;
        test_reset(1'b0);
        test_capture("basic", 1, 32'h0001_0001, 1, 5, 100, 100, 0, -1, -1);
        test_reset(1'b0);
        test_capture("defaults", 0, 32'h0, 0, 3, 60, 70, 0, -1, -1);
        test_capture("stall_rst", 1, 32'h0002_0003, 0, 4, 100, 100,
                     20, 3, -1);
        test_capture("after_rst", 0, 32'h0, 0, 2, 100, 100, 0, -1, -1);
        test_reset(1'b1);
        test_capture("wrap", 1, 32'h0000_0001, 0, 10, 100, 100, 0, -1, -1);
`ifdef CAPTURE_CTRL_ABORT_EN
        test_reset(1'b0);
        test_capture("abort", 1, 32'h0003_0002, 0, 3, 80, 100, 0, -1, 2);
        test_capture("post_abort", 1, 32'h0000_0000, 1, 2, 100, 100,
                     0, -1, -1);
`endif
        test_random(1'b0, 20);
        test_random(1'b1, 20);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, sample-memory address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_i  in  32  count word: [15:0] read field RD, [31:16] delay field DLY.
REQ-005 SHALL have port set_cnt_i  in  1  load cmd_i into count registers.
REQ-006 SHALL have port arm_i  in  1  start capture.
REQ-007 SHALL have port stb_i  in  1  sample strobe, one cycle per valid sample.
REQ-008 SHALL have port run_i  in  1  trigger fired; driven by the trigger's run_o.
REQ-009 SHALL have port tx_rdy_i  in  1  downstream transmitter accepts the current sample.
REQ-010 SHALL have port trg_arm_o  out  1  one-cycle arm pulse to the trigger's arm_i.
REQ-011 SHALL have port we_o  out  1  sample-memory write enable.
REQ-012 SHALL have port addr_o  out  ADDR_W  sample-memory address, shared by write and read.
REQ-013 SHALL have port rd_vld_o  out  1  memory read data valid for transmission.
REQ-014 SHALL have port busy_o  out  1  high in any state except IDLE.
REQ-015 SHALL have port done_o  out  1  one-cycle pulse when readout completes.

Function
REQ-016 SHALL implement the states IDLE, ARMED, DELAY and READOUT.
REQ-017 SHALL compute the read length as NR = min(4*(RD+1), DEPTH) samples.
REQ-018 SHALL compute the delay length as ND = 4*(DLY+1) samples, using a 19-bit counter.
REQ-019 SHALL load RD and DLY on set_cnt_i only in IDLE and SHALL ignore set_cnt_i in all other states.
REQ-020 SHALL, in IDLE on arm_i, move to ARMED and assert trg_arm_o for exactly that cycle.
REQ-021 SHALL, when set_cnt_i and arm_i coincide, load the new counts and use them for the capture.
REQ-022 SHALL, in ARMED and DELAY, assert we_o combinationally with stb_i, drive addr_o from wr_ptr, and increment wr_ptr after each write, wrapping DEPTH-1 -> 0.
REQ-023 SHALL ignore run_i in IDLE and READOUT.
REQ-024 SHALL, in ARMED on run_i, move to DELAY and load dly_cnt = ND.
REQ-025 SHALL, if stb_i coincides with run_i in ARMED, write that sample and count it as delay sample 1.
REQ-026 SHALL, in DELAY, decrement dly_cnt on each stb_i and, on the strobe that makes it 0, move to READOUT with rd_ptr = address of that last write and rd_cnt = NR.
REQ-027 SHALL, in READOUT, hold we_o at 0 and drive addr_o from rd_ptr.
REQ-028 SHALL, in READOUT, hold rd_vld_o low for exactly one cycle after entry and after each handshake, to cover the one-cycle RAM latency, then high until tx_rdy_i.
REQ-029 SHALL complete a handshake when rd_vld_o and tx_rdy_i are both high, then decrement rd_ptr (wrapping 0 -> DEPTH-1) and rd_cnt.
REQ-030 SHALL send samples newest first.
REQ-031 SHALL, on the handshake that makes rd_cnt 0, move to IDLE and pulse done_o for that cycle.
REQ-032 SHALL ignore tx_rdy_i while rd_vld_o is low.
REQ-033 SHALL ignore arm_i outside IDLE.

Reset
REQ-034 SHALL, with rst_i high at a clock edge, enter IDLE from any state, including mid-capture and mid-readout.
REQ-035 SHALL, on reset, clear wr_ptr, rd_ptr, dly_cnt and rd_cnt, and set RD and DLY to 0.
REQ-036 SHALL hold trg_arm_o, we_o, rd_vld_o, busy_o and done_o at 0, and addr_o at 0, during reset and in IDLE.

Configuration
REQ-037 SHALL, with macro CAPTURE_CTRL_ABORT_EN defined, add input abort_i (1 bit) that forces IDLE on the next edge from any state, without a done_o pulse and keeping wr_ptr.
REQ-038 SHALL, without CAPTURE_CTRL_ABORT_EN, have no abort_i port; only rst_i leaves a capture early.

Verification
REQ-039 SHALL cover: reset, then set_cnt_i with cmd_i=0x0001_0001, arm_i -> trg_arm_o one pulse, busy_o=1, state ARMED.
REQ-040 SHALL cover: in ARMED, 5 stb_i, then run_i, then 8 stb_i (DLY=1, ND=8) -> 13 writes at addr 0..12, READOUT entered after the 8th delay strobe, first rd addr 12.
REQ-041 SHALL cover: readout RD=1 (NR=8) with tx_rdy_i always high -> rd_vld_o alternating 0,1; addresses 12,11,...,5; done_o after 8th handshake; busy_o=0 after.
REQ-042 SHALL cover: ADDR_W=3, 10 pre-trigger strobes, ND=4 -> wr_ptr wraps, last write addr 5; readout NR=8 covers addresses 5,4,3,2,1,0,7,6.
REQ-043 SHALL cover: tx_rdy_i held low 20 cycles in READOUT -> rd_vld_o stays 1 and addr_o stays constant; rst_i mid-readout -> IDLE with all outputs 0 next cycle.
REQ-044 SHALL cover, with CAPTURE_CTRL_ABORT_EN: abort_i in DELAY -> IDLE, no done_o; then set_cnt_i accepted and a new arm_i pulses trg_arm_o.
